// File: rtl/fetch_sequencer_if.sv
// Bus bundle between fetch_sequencer (master side), the byte-wide instruction
// memory read port and the decode stage (slave side).
interface fetch_sequencer_if #(
    parameter int PC_W   = 64,
    parameter int ADDR_W = 10
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [PC_W-1:0]   instr_pc;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              fault;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        input  redirect_valid,
        input  redirect_pc,
        output fault
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        output redirect_valid,
        output redirect_pc,
        input  fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: four byte reads per word-indexed PC, assembled
// little-endian and handed to decode. Optional bounds check: FETCH_BOUNDS_CHECK_EN.
module fetch_sequencer #(
    parameter int              PC_W      = 64,
    parameter int              MEM_BYTES = 1024,
    parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    localparam int              ADDR_W = $clog2(MEM_BYTES);
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

`ifdef FETCH_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;
`endif

    state_t            state_r;
    logic [1:0]        k_r;
    logic [PC_W-1:0]   pc_r;
    logic              mem_en_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              cap_en_r;
    logic [1:0]        cap_idx_r;
    logic [7:0]        b0_r;
    logic [7:0]        b1_r;
    logic [7:0]        b2_r;
    logic              instr_valid_r;
    logic [31:0]       instr_r;
    logic [PC_W-1:0]   instr_pc_r;

    logic              handshake_s;
    logic              restart_s;
    logic [PC_W-1:0]   restart_pc_s;

    // Byte k of word pc: {pc,2'b00}+k never carries into pc, so it is {pc,k}.
    function automatic logic [ADDR_W-1:0] byte_addr(input logic [PC_W-1:0] pc,
                                                    input logic [1:0]      k);
        logic [PC_W+1:0] full;
        full = {pc, k};
        return full[ADDR_W-1:0];
    endfunction

`ifdef FETCH_BOUNDS_CHECK_EN
    logic fault_r;
    logic oob_s;

    // Last byte of the word compared at full width so large PCs cannot alias.
    function automatic logic out_of_range(input logic [PC_W-1:0] pc);
        logic [PC_W+1:0] last_byte;
        last_byte = {pc, 2'b11};
        return (last_byte >= (PC_W+2)'(MEM_BYTES));
    endfunction

    assign oob_s     = out_of_range(restart_pc_s);
    assign bus.fault = fault_r;
`else
    assign bus.fault = 1'b0;
`endif

    // Decide whether a new fetch starts at this edge and from which PC.
    always_comb begin
        handshake_s  = instr_valid_r && bus.instr_ready;
        restart_s    = 1'b0;
        restart_pc_s = pc_r;
        if (bus.redirect_valid) begin
            restart_s    = 1'b1;
            restart_pc_s = bus.redirect_pc;
        end else if (handshake_s) begin
            restart_s    = 1'b1;
            restart_pc_s = pc_r + PC_ONE;
        end else if ((state_r == ST_ISSUE) && (k_r == 2'd0)) begin
            restart_s    = 1'b1;
            restart_pc_s = pc_r;
        end else begin
            restart_s    = 1'b0;
            restart_pc_s = pc_r;
        end
    end

    // Fetch FSM, byte capture pipeline and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_ISSUE;
            k_r           <= 2'd0;
            pc_r          <= RESET_PC;
            mem_en_r      <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            cap_en_r      <= 1'b0;
            cap_idx_r     <= 2'd0;
            b0_r          <= 8'h00;
            b1_r          <= 8'h00;
            b2_r          <= 8'h00;
            instr_valid_r <= 1'b0;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= RESET_PC;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_r       <= 1'b0;
`endif
        end else begin
            // Read data lags its strobe by one cycle; a redirect kills it in flight.
            cap_en_r  <= mem_en_r && !bus.redirect_valid;
            cap_idx_r <= mem_addr_r[1:0];
            if (cap_en_r && !bus.redirect_valid) begin
                case (cap_idx_r)
                    2'd0:    b0_r <= bus.mem_rdata;
                    2'd1:    b1_r <= bus.mem_rdata;
                    2'd2:    b2_r <= bus.mem_rdata;
                    default: b2_r <= b2_r;
                endcase
            end

            if (restart_s) begin
                pc_r          <= restart_pc_s;
                instr_valid_r <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
                if (oob_s) begin
                    state_r  <= ST_FAULT;
                    k_r      <= 2'd0;
                    mem_en_r <= 1'b0;
                    fault_r  <= 1'b1;
                end else begin
                    state_r    <= ST_ISSUE;
                    k_r        <= 2'd1;
                    mem_en_r   <= 1'b1;
                    mem_addr_r <= byte_addr(restart_pc_s, 2'd0);
                    fault_r    <= 1'b0;
                end
`else
                state_r    <= ST_ISSUE;
                k_r        <= 2'd1;
                mem_en_r   <= 1'b1;
                mem_addr_r <= byte_addr(restart_pc_s, 2'd0);
`endif
            end else begin
                case (state_r)
                    ST_ISSUE: begin
                        mem_en_r   <= 1'b1;
                        mem_addr_r <= byte_addr(pc_r, k_r);
                        k_r        <= k_r + 2'd1;
                        if (k_r == 2'd3) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end
                    ST_DRAIN: begin
                        // b3 is taken straight off the read port as HOLD is entered.
                        mem_en_r <= 1'b0;
                        if (cap_en_r && (cap_idx_r == 2'd3)) begin
                            instr_r       <= {bus.mem_rdata, b2_r, b1_r, b0_r};
                            instr_pc_r    <= pc_r;
                            instr_valid_r <= 1'b1;
                            state_r       <= ST_HOLD;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end
                    ST_HOLD: begin
                        mem_en_r <= 1'b0;
                        state_r  <= ST_HOLD;
                    end
`ifdef FETCH_BOUNDS_CHECK_EN
                    ST_FAULT: begin
                        mem_en_r <= 1'b0;
                        fault_r  <= 1'b1;
                        state_r  <= ST_FAULT;
                    end
`endif
                    default: begin
                        state_r       <= ST_ISSUE;
                        k_r           <= 2'd0;
                        mem_en_r      <= 1'b0;
                        instr_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_en      = mem_en_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.instr       = instr_r;
    assign bus.instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// stream checked against a word-level memory/PC reference model.
module tb_fetch_sequencer;

    localparam int PC_W      = 64;
    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 10;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0]        mem [0:MEM_BYTES-1];
    logic [ADDR_W-1:0] seen[$];

    fetch_sequencer_if #(.PC_W(PC_W), .ADDR_W(ADDR_W)) bus ();

    fetch_sequencer #(
        .PC_W(PC_W),
        .MEM_BYTES(MEM_BYTES),
        .RESET_PC(64'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic longint unsigned word_base(input logic [PC_W-1:0] pc);
        longint unsigned p;
        p = pc;
        return (p * 64'd4) % 64'(MEM_BYTES);
    endfunction

    function automatic logic [31:0] model_instr(input logic [PC_W-1:0] pc);
        longint unsigned b;
        b = word_base(pc);
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    function automatic logic [43:0] pack_exp(input logic [PC_W-1:0] pc);
        longint unsigned b;
        b = word_base(pc);
        return {4'd4, ADDR_W'(b), ADDR_W'(b + 1), ADDR_W'(b + 2), ADDR_W'(b + 3)};
    endfunction

    function automatic logic [43:0] pack_seen();
        logic [43:0] r;
        r = 44'd0;
        r[43:40] = (seen.size() > 15) ? 4'd15 : 4'(seen.size());
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) r[39-10*i -: 10] = seen[i];
        end
        return r;
    endfunction

    // Log strobes from the current negedge until instr_valid (or budget runs out).
    task automatic collect(input int budget, output int first_c, output int valid_c);
        seen.delete();
        first_c = -1;
        valid_c = -1;
        for (int c = 0; c < budget; c++) begin
            if (bus.mem_en) begin
                seen.push_back(bus.mem_addr);
                if (first_c < 0) first_c = c;
            end
            if (bus.instr_valid) begin
                valid_c = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic redirect_to(input logic [PC_W-1:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        int f, v;
        bus.instr_ready = 1'b1;
        mem[0] = 8'h20; mem[1] = 8'h13; mem[2] = 8'h24; mem[3] = 8'h30;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %0h expected 0", bus.mem_en); end
        checks++; if (bus.mem_addr !== 10'd0) begin errors++; $display("FAIL reset_mem_addr got %0h expected 0", bus.mem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h expected 0", bus.instr_valid); end
        checks++; if (bus.instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %0h expected 0", bus.instr); end
        checks++; if (bus.instr_pc !== 64'd0) begin errors++; $display("FAIL reset_instr_pc got %0h expected 0", bus.instr_pc); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0h expected 0", bus.fault); end
        rst_n = 1'b1;
        @(negedge clk);
        collect(30, f, v);
        checks++; if (f !== 0) begin errors++; $display("FAIL first_strobe_cycle got %0d expected 0", f); end
        checks++; if (v - f !== 5) begin errors++; $display("FAIL fetch_latency got %0d expected 5", v - f); end
        checks++; if (pack_seen() !== pack_exp(64'd0)) begin errors++; $display("FAIL reset_addrs got %0h expected %0h", pack_seen(), pack_exp(64'd0)); end
        checks++; if (bus.instr !== 32'h3024_1320) begin errors++; $display("FAIL first_instr got %0h expected 30241320", bus.instr); end
        checks++; if (bus.instr_pc !== 64'd0) begin errors++; $display("FAIL first_instr_pc got %0h expected 0", bus.instr_pc); end
    endtask

    task automatic test_stall();
        int f, v, bad;
        bus.instr_ready = 1'b0;
        redirect_to(64'd0);
        collect(30, f, v);
        checks++; if (v < 0) begin errors++; $display("FAIL stall_wait_valid got timeout expected valid"); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.instr_valid !== 1'b1 || bus.mem_en !== 1'b0 || bus.instr !== model_instr(64'd0) || bus.instr_pc !== 64'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable got %0d bad cycles expected 0", bad); end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd4) begin errors++; $display("FAIL stall_release_strobe got en=%0h addr=%0d expected en=1 addr=4", bus.mem_en, bus.mem_addr); end
        collect(30, f, v);
        checks++; if (pack_seen() !== pack_exp(64'd1)) begin errors++; $display("FAIL stall_next_addrs got %0h expected %0h", pack_seen(), pack_exp(64'd1)); end
        checks++; if (bus.instr_pc !== 64'd1 || bus.instr !== model_instr(64'd1)) begin errors++; $display("FAIL stall_next_instr got pc=%0h instr=%0h expected pc=1 instr=%0h", bus.instr_pc, bus.instr, model_instr(64'd1)); end
    endtask

    task automatic test_redirect_mid();
        int f, v;
        bit found;
        bus.instr_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mem_en && bus.mem_addr[1:0] == 2'd2) begin found = 1'b1; break; end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL redir_find_byte2 got timeout expected strobe"); end
        redirect_to(64'd3);
        collect(30, f, v);
        checks++; if (f !== 0 || v - f !== 5) begin errors++; $display("FAIL redir_timing got first=%0d lat=%0d expected 0 and 5", f, v - f); end
        checks++; if (pack_seen() !== pack_exp(64'd3)) begin errors++; $display("FAIL redir_addrs got %0h expected %0h", pack_seen(), pack_exp(64'd3)); end
        checks++; if (bus.instr_pc !== 64'd3 || bus.instr !== model_instr(64'd3)) begin errors++; $display("FAIL redir_instr got pc=%0h instr=%0h expected pc=3 instr=%0h", bus.instr_pc, bus.instr, model_instr(64'd3)); end
    endtask

    task automatic test_hs_redirect();
        int f, v;
        bus.instr_ready = 1'b0;
        collect(30, f, v);
        checks++; if (v < 0) begin errors++; $display("FAIL hsr_wait_valid got timeout expected valid"); end
        bus.instr_ready = 1'b1;
        redirect_to(64'd2);
        bus.instr_ready = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL hsr_valid_drop got %0h expected 0", bus.instr_valid); end
        collect(30, f, v);
        checks++; if (pack_seen() !== pack_exp(64'd2)) begin errors++; $display("FAIL hsr_addrs got %0h expected %0h", pack_seen(), pack_exp(64'd2)); end
        checks++; if (bus.instr_pc !== 64'd2 || bus.instr !== model_instr(64'd2)) begin errors++; $display("FAIL hsr_instr got pc=%0h instr=%0h expected pc=2 instr=%0h", bus.instr_pc, bus.instr, model_instr(64'd2)); end
    endtask

    task automatic test_bounds();
        int f, v;
        bus.instr_ready = 1'b1;
        redirect_to(64'd256);
`ifdef FETCH_BOUNDS_CHECK_EN
        begin
            int strobes, fault_lo;
            checks++; if (bus.fault !== 1'b1 || bus.mem_en !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL bounds_enter got fault=%0h en=%0h valid=%0h expected 1,0,0", bus.fault, bus.mem_en, bus.instr_valid); end
            strobes = 0; fault_lo = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus.mem_en) strobes++;
                if (bus.fault !== 1'b1) fault_lo++;
            end
            checks++; if (strobes !== 0 || fault_lo !== 0) begin errors++; $display("FAIL bounds_hold got strobes=%0d fault_drops=%0d expected 0,0", strobes, fault_lo); end
            redirect_to(64'd0);
            checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL bounds_clear got %0h expected 0", bus.fault); end
            collect(30, f, v);
            checks++; if (pack_seen() !== pack_exp(64'd0) || bus.instr_pc !== 64'd0) begin errors++; $display("FAIL bounds_resume got %0h pc=%0h expected %0h pc=0", pack_seen(), bus.instr_pc, pack_exp(64'd0)); end
        end
`else
        collect(30, f, v);
        checks++; if (pack_seen() !== pack_exp(64'd0)) begin errors++; $display("FAIL wrap_addrs got %0h expected %0h", pack_seen(), pack_exp(64'd0)); end
        checks++; if (bus.instr_pc !== 64'd256 || bus.instr !== model_instr(64'd256)) begin errors++; $display("FAIL wrap_instr got pc=%0h instr=%0h expected pc=100 instr=%0h", bus.instr_pc, bus.instr, model_instr(64'd256)); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL wrap_fault got %0h expected 0", bus.fault); end
`endif
    endtask

    task automatic test_async_reset();
        int f, v;
        bit found;
        bus.instr_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mem_en && bus.mem_addr[1:0] == 2'd1) begin found = 1'b1; break; end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL arst_find_byte1 got timeout expected strobe"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("FAIL arst_immediate got valid=%0h en=%0h fault=%0h expected 0,0,0", bus.instr_valid, bus.mem_en, bus.fault); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        collect(30, f, v);
        checks++; if (pack_seen() !== pack_exp(64'd0) || bus.instr_pc !== 64'd0 || bus.instr !== model_instr(64'd0)) begin errors++; $display("FAIL arst_restart got %0h pc=%0h instr=%0h expected %0h pc=0", pack_seen(), bus.instr_pc, bus.instr, pack_exp(64'd0)); end
    endtask

    task automatic test_random();
        logic [PC_W-1:0] exp_pc;
        int  n_valid;
        bit  redir;
        n_valid = 0;
        bus.instr_ready = 1'b0;
        exp_pc = 64'($urandom_range(0, 63));
        redirect_to(exp_pc);
        for (int c = 0; c < 800; c++) begin
            if (bus.mem_en) begin
                checks++; if (bus.mem_addr[9:2] !== exp_pc[7:0]) begin errors++; $display("FAIL rand_strobe got %0d expected word %0d", bus.mem_addr, exp_pc[7:0]); end
            end
            if (bus.instr_valid) begin
                n_valid++;
                checks++; if (bus.instr_pc !== exp_pc || bus.instr !== model_instr(exp_pc)) begin errors++; $display("FAIL rand_instr got pc=%0h instr=%0h expected pc=%0h instr=%0h", bus.instr_pc, bus.instr, exp_pc, model_instr(exp_pc)); end
            end
            checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL rand_fault got %0h expected 0", bus.fault); end
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0) || (exp_pc >= 64'd200);
            bus.redirect_valid = redir;
            if (redir) bus.redirect_pc = 64'($urandom_range(0, 127));
            if (redir) exp_pc = bus.redirect_pc;
            else if (bus.instr_valid && bus.instr_ready) exp_pc = exp_pc + 64'd1;
            @(negedge clk);
        end
        bus.redirect_valid = 1'b0;
        checks++; if (n_valid < 10) begin errors++; $display("FAIL rand_progress got %0d valid cycles expected at least 10", n_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        test_reset();
        test_stall();
        test_redirect_mid();
        test_hs_redirect();
        test_bounds();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
